// File: rtl/task_sched_pkg.sv
// Shared definitions for the task queue scheduler.
// Holds the default sizing, command opcodes, the queue-entry type, the FSM
// state type and the per-slot load selector used between the top and its cells.
package task_sched_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int TID_W_DEF  = 4;
  localparam int INFO_W_DEF = 32;

  localparam logic [2:0] OP_ENQ      = 3'd0;
  localparam logic [2:0] OP_DEQ      = 3'd1;
  localparam logic [2:0] OP_REMOVE   = 3'd2;
  localparam logic [2:0] OP_BLOCK    = 3'd3;
  localparam logic [2:0] OP_ACTIVATE = 3'd4;

  typedef struct packed {
    logic                  valid;
    logic                  blk;
    logic [TID_W_DEF-1:0]  tid;
    logic [INFO_W_DEF-1:0] info;
  } queue_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } sched_state_e;

  typedef enum logic [2:0] {
    CELL_HOLD,
    CELL_NEW,
    CELL_LEFT,
    CELL_RIGHT,
    CELL_SET_BLK,
    CELL_CLR_BLK
  } cell_sel_e;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op > OP_ACTIVATE;
  endfunction

endpackage

// File: rtl/task_queue_cell.sv
// One queue slot {valid, blk, tid, info}.
// Ports: clk, rst (sync, active-high); sel picks hold / load new entry /
// load from left (toward head) or right (toward tail) neighbour / set or clear
// blk; dec is the saturating decrement applied to info while holding a valid
// entry; new_*, left_*, right_* are the load sources; valid/blk/tid/info are
// the slot contents.
module task_queue_cell
  import task_sched_pkg::*;
#(
  parameter int TID_W  = TID_W_DEF,
  parameter int INFO_W = INFO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  cell_sel_e         sel,
  input  logic [1:0]        dec,
  input  logic [TID_W-1:0]  new_tid,
  input  logic [INFO_W-1:0] new_info,
  input  logic              left_valid,
  input  logic              left_blk,
  input  logic [TID_W-1:0]  left_tid,
  input  logic [INFO_W-1:0] left_info,
  input  logic              right_valid,
  input  logic              right_blk,
  input  logic [TID_W-1:0]  right_tid,
  input  logic [INFO_W-1:0] right_info,
  output logic              valid,
  output logic              blk,
  output logic [TID_W-1:0]  tid,
  output logic [INFO_W-1:0] info
);

  logic [INFO_W-1:0] dec_w;
  logic [INFO_W-1:0] info_dec;

  assign dec_w    = INFO_W'(dec);
  assign info_dec = (info > dec_w) ? info - dec_w : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      blk   <= 1'b0;
      tid   <= '0;
      info  <= '0;
    end else begin
      case (sel)
        CELL_NEW: begin
          valid <= 1'b1;
          blk   <= 1'b0;
          tid   <= new_tid;
          info  <= new_info;
        end
        CELL_LEFT: begin
          valid <= left_valid;
          blk   <= left_blk;
          tid   <= left_tid;
          info  <= left_info;
        end
        CELL_RIGHT: begin
          valid <= right_valid;
          blk   <= right_blk;
          tid   <= right_tid;
          info  <= right_info;
        end
        CELL_SET_BLK: blk <= 1'b1;
        CELL_CLR_BLK: blk <= 1'b0;
        default: begin
          if (valid) info <= info_dec;
        end
      endcase
    end
  end

endmodule

// File: rtl/task_queue_scheduler.sv
// Deadline-sorted task queue with blocking, removal and a scheduler tick.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready handshake with
// cmd_op, cmd_tid, cmd_info; tick decrements all deadlines; head_* expose the
// most urgent non-blocked entry; count/full/empty report occupancy; err pulses
// for a rejected command.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a command; ticks decrement the queue directly
// ST_EXEC | latched command is applied; a tick here is held for one cycle
module task_queue_scheduler
  import task_sched_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  TID_W  = TID_W_DEF,
  parameter int  INFO_W = INFO_W_DEF,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [TID_W-1:0]  cmd_tid,
  input  logic [INFO_W-1:0] cmd_info,
  input  logic              tick,
  output logic              head_valid,
  output logic [TID_W-1:0]  head_tid,
  output logic [INFO_W-1:0] head_info,
  output logic              head_expired,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  sched_state_e      state_q, state_d;
  logic              tick_pend_q;
  logic [2:0]        op_q;
  logic [TID_W-1:0]  tid_q;
  logic [INFO_W-1:0] info_q;

  logic [DEPTH-1:0]  slot_valid, slot_blk;
  logic [TID_W-1:0]  slot_tid  [DEPTH];
  logic [INFO_W-1:0] slot_info [DEPTH];
  cell_sel_e         cell_sel  [DEPTH];

  logic              accept, exec, cmd_err;
  logic [1:0]        dec_amt;
  logic              match_found, head_found;
  logic [CNT_W-1:0]  match_idx, head_idx, ins_pos, count_c;
  logic [TID_W-1:0]  head_tid_c;
  logic [INFO_W-1:0] head_info_c;

  assign accept = cmd_valid && cmd_ready;
  assign exec   = (state_q == ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_pend_q <= 1'b0;
      op_q        <= '0;
      tid_q       <= '0;
      info_q      <= '0;
    end else begin
      state_q     <= state_d;
      tick_pend_q <= exec && tick;
      if (accept) begin
        op_q   <= cmd_op;
        tid_q  <= cmd_tid;
        info_q <= cmd_info;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    err       = exec && cmd_err;
  end

  // Valid entries are always packed into slots 0..count-1 in ascending info,
  // so the number of entries with info <= new info is the insertion slot and
  // places a new entry after any equal ones.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    head_found  = 1'b0;
    head_idx    = '0;
    head_tid_c  = '0;
    head_info_c = '0;
    ins_pos     = '0;
    count_c     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        count_c = count_c + CNT_W'(1);
        if (slot_info[i] <= info_q) ins_pos = ins_pos + CNT_W'(1);
        if (!match_found && slot_tid[i] == tid_q) begin
          match_found = 1'b1;
          match_idx   = CNT_W'(i);
        end
        if (!head_found && !slot_blk[i]) begin
          head_found  = 1'b1;
          head_idx    = CNT_W'(i);
          head_tid_c  = slot_tid[i];
          head_info_c = slot_info[i];
        end
      end
    end
  end

  always_comb begin
    cmd_err = 1'b0;
    if (op_is_reserved(op_q)) begin
      cmd_err = 1'b1;
    end else begin
      case (op_q)
        OP_ENQ:  cmd_err = full || match_found;
        OP_DEQ:  cmd_err = !head_found;
        default: cmd_err = !match_found;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cell_sel[i] = CELL_HOLD;
      if (exec && !cmd_err) begin
        case (op_q)
          OP_ENQ: begin
            if (CNT_W'(i) == ins_pos)     cell_sel[i] = CELL_NEW;
            else if (CNT_W'(i) > ins_pos) cell_sel[i] = CELL_LEFT;
          end
          OP_DEQ:      if (CNT_W'(i) >= head_idx)  cell_sel[i] = CELL_RIGHT;
          OP_REMOVE:   if (CNT_W'(i) >= match_idx) cell_sel[i] = CELL_RIGHT;
          OP_BLOCK:    if (CNT_W'(i) == match_idx) cell_sel[i] = CELL_SET_BLK;
          OP_ACTIVATE: if (CNT_W'(i) == match_idx) cell_sel[i] = CELL_CLR_BLK;
          default: ;
        endcase
      end
    end
  end

  // A tick seen during EXEC lands in the following IDLE cycle together with
  // any fresh tick there, so the decrement can be 0, 1 or 2.
  assign dec_amt = exec ? 2'd0 : ({1'b0, tick} + {1'b0, tick_pend_q});

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic              l_valid, l_blk, r_valid, r_blk;
    logic [TID_W-1:0]  l_tid, r_tid;
    logic [INFO_W-1:0] l_info, r_info;

    if (g == 0) begin : g_left_edge
      assign l_valid = 1'b0;
      assign l_blk   = 1'b0;
      assign l_tid   = '0;
      assign l_info  = '0;
    end else begin : g_left
      assign l_valid = slot_valid[g-1];
      assign l_blk   = slot_blk[g-1];
      assign l_tid   = slot_tid[g-1];
      assign l_info  = slot_info[g-1];
    end

    if (g == DEPTH-1) begin : g_right_edge
      assign r_valid = 1'b0;
      assign r_blk   = 1'b0;
      assign r_tid   = '0;
      assign r_info  = '0;
    end else begin : g_right
      assign r_valid = slot_valid[g+1];
      assign r_blk   = slot_blk[g+1];
      assign r_tid   = slot_tid[g+1];
      assign r_info  = slot_info[g+1];
    end

    task_queue_cell #(.TID_W(TID_W), .INFO_W(INFO_W)) u_cell (
      .clk         (clk),
      .rst         (rst),
      .sel         (cell_sel[g]),
      .dec         (dec_amt),
      .new_tid     (tid_q),
      .new_info    (info_q),
      .left_valid  (l_valid),
      .left_blk    (l_blk),
      .left_tid    (l_tid),
      .left_info   (l_info),
      .right_valid (r_valid),
      .right_blk   (r_blk),
      .right_tid   (r_tid),
      .right_info  (r_info),
      .valid       (slot_valid[g]),
      .blk         (slot_blk[g]),
      .tid         (slot_tid[g]),
      .info        (slot_info[g])
    );
  end

  assign count        = count_c;
  assign full         = (count_c == CNT_W'(DEPTH));
  assign empty        = (count_c == '0);
  assign head_valid   = head_found;
  assign head_tid     = head_tid_c;
  assign head_info    = head_info_c;
  assign head_expired = head_found && (head_info_c == '0);

endmodule

// File: tb/tb_task_queue_scheduler.sv
module tb_task_queue_scheduler;
  import task_sched_pkg::*;

  localparam int DEPTH  = 8;
  localparam int TID_W  = 4;
  localparam int INFO_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [2:0]        cmd_op;
  logic [TID_W-1:0]  cmd_tid;
  logic [INFO_W-1:0] cmd_info;
  logic              tick;
  logic              head_valid, head_expired, full, empty, err;
  logic [TID_W-1:0]  head_tid;
  logic [INFO_W-1:0] head_info;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  task_queue_scheduler #(.DEPTH(DEPTH), .TID_W(TID_W), .INFO_W(INFO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_tid      (cmd_tid),
    .cmd_info     (cmd_info),
    .tick         (tick),
    .head_valid   (head_valid),
    .head_tid     (head_tid),
    .head_info    (head_info),
    .head_expired (head_expired),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err          (err)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: the queue contents as an ordered list, most urgent first.
  queue_entry_t mq[$];

  typedef struct {
    int         kind;   // 0 = command, 1 = idle cycle with tick
    logic [2:0] op;
    int         tid;
    int         info;
    bit         e_err;
    bit         e_hv;
    int         e_tid;
    int         e_info;
    bit         e_exp;
    int         e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int find_tid(input logic [TID_W-1:0] t);
    foreach (mq[i]) if (mq[i].tid == t) return i;
    return -1;
  endfunction

  function automatic int find_head();
    foreach (mq[i]) if (!mq[i].blk) return i;
    return -1;
  endfunction

  function automatic void model_dec(input int n);
    foreach (mq[i]) mq[i].info = (mq[i].info > 32'(n)) ? mq[i].info - 32'(n) : 32'd0;
  endfunction

  // Returns 1 when the command must be rejected (queue left untouched).
  function automatic bit model_exec(input logic [2:0] op, input logic [TID_W-1:0] t,
                                    input logic [INFO_W-1:0] inf);
    int k;
    queue_entry_t e;
    k = find_tid(t);
    case (op)
      OP_ENQ: begin
        if (mq.size() >= DEPTH || k >= 0) return 1'b1;
        e.valid = 1'b1;
        e.blk   = 1'b0;
        e.tid   = t;
        e.info  = inf;
        k = 0;
        while (k < mq.size() && mq[k].info <= inf) k++;
        mq.insert(k, e);
        return 1'b0;
      end
      OP_DEQ: begin
        k = find_head();
        if (k < 0) return 1'b1;
        mq.delete(k);
        return 1'b0;
      end
      OP_REMOVE: begin
        if (k < 0) return 1'b1;
        mq.delete(k);
        return 1'b0;
      end
      OP_BLOCK: begin
        if (k < 0) return 1'b1;
        mq[k].blk = 1'b1;
        return 1'b0;
      end
      OP_ACTIVATE: begin
        if (k < 0) return 1'b1;
        mq[k].blk = 1'b0;
        return 1'b0;
      end
      default: return 1'b1;
    endcase
  endfunction

  function automatic void check_state(input string tag);
    int h;
    h = find_head();
    check($sformatf("%s.count", tag), count, mq.size());
    check($sformatf("%s.full", tag), full, mq.size() == DEPTH);
    check($sformatf("%s.empty", tag), empty, mq.size() == 0);
    if (h >= 0) begin
      check($sformatf("%s.head_valid", tag), head_valid, 1);
      check($sformatf("%s.head_tid", tag), head_tid, mq[h].tid);
      check($sformatf("%s.head_info", tag), head_info, mq[h].info);
      check($sformatf("%s.head_expired", tag), head_expired, mq[h].info == 0);
    end else begin
      check($sformatf("%s.head_valid", tag), head_valid, 0);
      check($sformatf("%s.head_tid", tag), head_tid, 0);
      check($sformatf("%s.head_info", tag), head_info, 0);
      check($sformatf("%s.head_expired", tag), head_expired, 0);
    end
  endfunction

  // Accept in cycle N (tick t0), execute in N+1 (tick t1), results sampled in
  // N+2 (tick t2 driven there, applied with the deferred t1 at the end of N+2).
  task automatic do_cmd(input logic [2:0] op, input int tid, input int info,
                        input bit t0, input bit t1, input bit t2, output logic got_err);
    bit exp_err;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tid   = TID_W'(tid);
    cmd_info  = INFO_W'(info);
    tick      = t0;
    check("ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tick      = t1;
    model_dec(int'(t0));
    exp_err = model_exec(op, TID_W'(tid), INFO_W'(info));
    got_err = err;
    check($sformatf("err_exec op%0d tid%0d", op, tid), err, exp_err);
    check("ready_exec", cmd_ready, 0);
    @(posedge clk); #1;
    tick = t2;
    check("err_pulse_end", err, 0);
    check("ready_back", cmd_ready, 1);
    check_state("post_cmd");
    model_dec(int'(t1) + int'(t2));
  endtask

  task automatic idle_cycle(input bit t);
    @(posedge clk); #1;
    tick = t;
    @(posedge clk); #1;
    tick = 1'b0;
    model_dec(int'(t));
    check_state("idle");
  endtask

  function automatic void add(input int kind, input logic [2:0] op, input int tid, input int info,
                              input bit e_err, input bit e_hv, input int e_tid, input int e_info,
                              input bit e_exp, input int e_cnt);
    vec_t v;
    v.kind = kind; v.op = op; v.tid = tid; v.info = info;
    v.e_err = e_err; v.e_hv = e_hv; v.e_tid = e_tid; v.e_info = e_info;
    v.e_exp = e_exp; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    logic       e;
    logic [2:0] op;
    int         r;

    //   kind op          tid info  err hv tid info exp cnt
    add(0, OP_ENQ,      3,  50,  0, 1, 3, 50,  0, 1);
    add(0, OP_ENQ,      5,  20,  0, 1, 5, 20,  0, 2);
    add(0, OP_ENQ,      7,  20,  0, 1, 5, 20,  0, 3);
    add(0, OP_BLOCK,    5,   0,  0, 1, 7, 20,  0, 3);
    add(0, OP_DEQ,      0,   0,  0, 1, 3, 50,  0, 2);
    add(0, OP_ACTIVATE, 5,   0,  0, 1, 5, 20,  0, 2);
    add(0, OP_ENQ,      3,   1,  1, 1, 5, 20,  0, 2);
    add(0, OP_REMOVE,   9,   0,  1, 1, 5, 20,  0, 2);
    add(0, 3'd6,        5,   0,  1, 1, 5, 20,  0, 2);
    add(0, OP_BLOCK,   12,   0,  1, 1, 5, 20,  0, 2);
    add(0, OP_REMOVE,   5,   0,  0, 1, 3, 50,  0, 1);
    add(0, OP_BLOCK,    3,   0,  0, 0, 0,  0,  0, 1);
    add(0, OP_DEQ,      0,   0,  1, 0, 0,  0,  0, 1);
    add(0, OP_ACTIVATE, 3,   0,  0, 1, 3, 50,  0, 1);
    add(0, OP_REMOVE,   3,   0,  0, 0, 0,  0,  0, 0);
    add(0, OP_DEQ,      0,   0,  1, 0, 0,  0,  0, 0);
    for (int i = 0; i < 8; i++) add(0, OP_ENQ, i, 100 - i, 0, 1, i, 100 - i, 0, i + 1);
    add(0, OP_ENQ,      9,   5,  1, 1, 7, 93,  0, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < 7) add(0, OP_DEQ, 0, 0, 0, 1, 6 - k, 94 + k, 0, 7 - k);
      else       add(0, OP_DEQ, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    add(0, OP_ENQ,      2,   2,  0, 1, 2,  2,  0, 1);
    add(1, OP_ENQ,      0,   0,  0, 1, 2,  1,  0, 1);
    add(1, OP_ENQ,      0,   0,  0, 1, 2,  0,  1, 1);
    add(1, OP_ENQ,      0,   0,  0, 1, 2,  0,  1, 1);

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_tid = '0; cmd_info = '0; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.ready", cmd_ready, 1);
    check("reset.err", err, 0);
    check_state("reset");

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].kind == 1) begin
        idle_cycle(1'b1);
      end else begin
        do_cmd(vecs[v].op, vecs[v].tid, vecs[v].info, 1'b0, 1'b0, 1'b0, e);
        check($sformatf("vec%0d.err", v), e, vecs[v].e_err);
      end
      check($sformatf("vec%0d.head_valid", v), head_valid, vecs[v].e_hv);
      check($sformatf("vec%0d.head_tid", v), head_tid, vecs[v].e_tid);
      check($sformatf("vec%0d.head_info", v), head_info, vecs[v].e_info);
      check($sformatf("vec%0d.head_expired", v), head_expired, vecs[v].e_exp);
      check($sformatf("vec%0d.count", v), count, vecs[v].e_cnt);
    end

    // Tick during EXEC followed by a tick in the next cycle: decrement of 2.
    do_cmd(OP_REMOVE, 2, 0, 1'b0, 1'b0, 1'b0, e);
    do_cmd(OP_ENQ, 1, 10, 1'b0, 1'b0, 1'b0, e);
    do_cmd(OP_ENQ, 4, 40, 1'b0, 1'b1, 1'b1, e);
    check("exec_tick.before", head_info, 10);
    idle_cycle(1'b0);
    check("exec_tick.dec2", head_info, 8);

    // Tick in the accept cycle is seen before the insertion point is chosen.
    do_cmd(OP_ENQ, 6, 7, 1'b1, 1'b0, 1'b0, e);
    check("accept_tick.head_tid", head_tid, 1);
    check("accept_tick.head_info", head_info, 7);
    check("accept_tick.count", count, 3);

    // Reset while a command is executing.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_ENQ; cmd_tid = 4'd8; cmd_info = 32'd3; tick = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst = 1'b1;
    check("rst_exec.ready_in_exec", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    check("rst_exec.empty", empty, 1);
    check("rst_exec.count", count, 0);
    check("rst_exec.ready", cmd_ready, 1);
    check("rst_exec.err", err, 0);
    check_state("rst_exec");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle(1'($urandom_range(0, 1)));
      end else begin
        r = $urandom_range(0, 19);
        if (r < 8)       op = OP_ENQ;
        else if (r < 11) op = OP_DEQ;
        else if (r < 14) op = OP_REMOVE;
        else if (r < 16) op = OP_BLOCK;
        else if (r < 18) op = OP_ACTIVATE;
        else             op = 3'($urandom_range(5, 7));
        do_cmd(op, $urandom_range(0, 15), $urandom_range(0, 40),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
